// File: rtl/esc_pkg.sv
// Shared types and default constants for the ESC pulse-width capture block.
package esc_pkg;

    typedef enum logic {
        WAIT_RISE = 1'b0,
        MEASURE   = 1'b1
    } esc_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 15;
    localparam int DEF_OFFSET  = 0;
    localparam int DEF_TMO_CYC = 32'h0001_0000;

endpackage

// File: rtl/esc_chan.sv
// One ESC channel: input synchronizer, pulse-width FSM, saturating counter,
// sticky overflow flag and stale-input watchdog.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   WAIT_RISE | idle, waiting for a synchronized rising edge
//   MEASURE   | pulse high, counting cycles until the falling edge
module esc_chan
    import esc_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] OFFSET  = CNT_W'(DEF_OFFSET),
    parameter int               TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             esc_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] pw,
    output logic             pw_vld,
    output logic             stale,
    output logic             ovf
);

    localparam int               WD_W    = $clog2(TMO_CYC) + 1;
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TMO_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1, s2, s3;
    logic [1:0]       prime;
    logic             armed;
    logic             rise, fall;
    esc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;

    // A rise only counts once s2 has been seen low with real data behind it,
    // so a pulse already high when reset releases is never captured.
    assign rise  = armed & s2 & ~s3;
    assign fall  = ~s2 & s3;
    assign stale = (wd == WD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            prime <= '0;
            armed <= 1'b0;
        end else begin
            s1    <= esc_in;
            s2    <= s1;
            s3    <= s2;
            prime <= {prime[0], 1'b1};
            armed <= armed | (prime[1] & ~s2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= WAIT_RISE;
            cnt    <= '0;
            pw     <= '0;
            pw_vld <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            pw_vld <= 1'b0;
            if (clr_err)
                ovf <= 1'b0;
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        pw     <= (cnt > OFFSET) ? (cnt - OFFSET) : '0;
                        pw_vld <= 1'b1;
                        state  <= WAIT_RISE;
                    end else if (s2 && (cnt != CNT_MAX)) begin
                        cnt <= cnt + 1'b1;
                        // placed after the clear so a same-cycle saturation wins
                        if (cnt == CNT_MAX - 1'b1)
                            ovf <= 1'b1;
                    end
                end
                default: state <= WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd <= '0;
        else if (rise)
            wd <= '0;
        else if (wd != WD_MAX)
            wd <= wd + 1'b1;
    end

endmodule

// File: rtl/esc_capture.sv
// Multi-channel ESC pulse capture: per-channel measurement plus frame
// tracking and total-throttle sum across all channels.
module esc_capture
    import esc_pkg::*;
#(
    parameter int               NUM_CH  = DEF_NUM_CH,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] OFFSET  = CNT_W'(DEF_OFFSET),
    parameter int               TMO_CYC = DEF_TMO_CYC
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                esc_in,
    input  logic                             clr_err,
    output logic [NUM_CH*CNT_W-1:0]          pw,
    output logic [NUM_CH-1:0]                pw_vld,
    output logic                             frame_done,
    output logic [CNT_W+$clog2(NUM_CH)-1:0]  thrst,
    output logic [NUM_CH-1:0]                stale,
    output logic [NUM_CH-1:0]                ovf
);

    localparam int TW = CNT_W + $clog2(NUM_CH);

    logic [NUM_CH-1:0] seen;
    logic              all_seen;
    logic [TW-1:0]     sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        esc_chan #(
            .CNT_W   (CNT_W),
            .OFFSET  (OFFSET),
            .TMO_CYC (TMO_CYC)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .esc_in  (esc_in[i]),
            .clr_err (clr_err),
            .pw      (pw[i*CNT_W +: CNT_W]),
            .pw_vld  (pw_vld[i]),
            .stale   (stale[i]),
            .ovf     (ovf[i])
        );
    end

    assign all_seen = &(seen | pw_vld);

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            sum = sum + TW'(pw[i*CNT_W +: CNT_W]);
    end

    // pw already holds the frame's final captures when all_seen is true,
    // so thrst and frame_done land together on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen       <= '0;
            frame_done <= 1'b0;
            thrst      <= '0;
        end else begin
            frame_done <= all_seen;
            if (all_seen) begin
                seen  <= '0;
                thrst <= sum;
            end else begin
                seen <= seen | pw_vld;
            end
        end
    end

endmodule

// File: tb/tb_esc_capture.sv
// Self-checking bench for esc_capture: three configurations checked against a
// pulse-level reference model (capture values, capture timing, frame completion).
module tb_esc_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_err;
    logic [3:0]  esc_a, esc_b, esc_c;

    logic [59:0] pw_a, pw_b;
    logic [31:0] pw_c;
    logic [3:0]  pw_vld_a, pw_vld_b, pw_vld_c;
    logic        frame_done_a, frame_done_b, frame_done_c;
    logic [16:0] thrst_a, thrst_b;
    logic [9:0]  thrst_c;
    logic [3:0]  stale_a, stale_b, stale_c;
    logic [3:0]  ovf_a, ovf_b, ovf_c;

    int n_tests = 0;
    int n_fail  = 0;

    esc_capture u_dut_a (
        .clk(clk), .rst(rst), .esc_in(esc_a), .clr_err(clr_err),
        .pw(pw_a), .pw_vld(pw_vld_a), .frame_done(frame_done_a),
        .thrst(thrst_a), .stale(stale_a), .ovf(ovf_a)
    );

    esc_capture #(.OFFSET(15'd50)) u_dut_b (
        .clk(clk), .rst(rst), .esc_in(esc_b), .clr_err(clr_err),
        .pw(pw_b), .pw_vld(pw_vld_b), .frame_done(frame_done_b),
        .thrst(thrst_b), .stale(stale_b), .ovf(ovf_b)
    );

    esc_capture #(.CNT_W(8), .OFFSET(8'd0), .TMO_CYC(1000)) u_dut_c (
        .clk(clk), .rst(rst), .esc_in(esc_c), .clr_err(clr_err),
        .pw(pw_c), .pw_vld(pw_vld_c), .frame_done(frame_done_c),
        .thrst(thrst_c), .stale(stale_c), .ovf(ovf_c)
    );

    // Expected capture for an H-cycle pulse: saturate to counter range, subtract offset, floor at 0.
    function automatic int exp_pw(input int h, input int w, input int off);
        int mx = (1 << w) - 1;
        int c  = (h > mx) ? mx : h;
        return (c > off) ? (c - off) : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        esc_a = '0; esc_b = '0; esc_c = '0; clr_err = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
    endtask

    // Pulse i of channel ch is high for samples st..st+wd-1; its capture is
    // visible after the edge at sample st+wd+2. Frame completes when every
    // channel has captured since the last completion; strobe follows 1 cycle later.
    task automatic run_a(input string name, input int st[4], input int wd[4],
                         input int st2[4], input int wd2[4], input bit rst_first);
        bit [3:0] cap_at[2000];
        int       cap_v[2000][4];
        bit       done_exp[2000];
        int       thr_exp[2000];
        int       last[4];
        bit [3:0] seen_m;
        bit [3:0] drv;
        int       len;
        int       c_end;
        if (rst_first) do_reset();
        len = 0;
        for (int ch = 0; ch < 4; ch++) begin
            last[ch] = 0;
            if (wd[ch] > 0) begin
                c_end = st[ch] + wd[ch] + 2;
                cap_at[c_end][ch] = 1'b1;
                cap_v[c_end][ch]  = exp_pw(wd[ch], 15, 0);
                if (c_end > len) len = c_end;
            end
            if (wd2[ch] > 0) begin
                c_end = st2[ch] + wd2[ch] + 2;
                cap_at[c_end][ch] = 1'b1;
                cap_v[c_end][ch]  = exp_pw(wd2[ch], 15, 0);
                if (c_end > len) len = c_end;
            end
        end
        len = len + 5;
        seen_m = '0;
        for (int c = 0; c < len; c++) begin
            for (int ch = 0; ch < 4; ch++)
                if (cap_at[c][ch]) last[ch] = cap_v[c][ch];
            seen_m = seen_m | cap_at[c];
            if (seen_m == 4'hf) begin
                done_exp[c+1] = 1'b1;
                thr_exp[c+1]  = last[0] + last[1] + last[2] + last[3];
                seen_m = '0;
            end
        end
        for (int c = 0; c < len + 2; c++) begin
            for (int ch = 0; ch < 4; ch++)
                drv[ch] = ((wd[ch]  > 0) && (c >= st[ch])  && (c < st[ch]  + wd[ch])) ||
                          ((wd2[ch] > 0) && (c >= st2[ch]) && (c < st2[ch] + wd2[ch]));
            esc_a = drv;
            tick();
            n_tests++;
            if (pw_vld_a !== cap_at[c]) begin
                n_fail++;
                $display("FAIL %s pw_vld cyc %0d: got %b want %b", name, c, pw_vld_a, cap_at[c]);
            end
            n_tests++;
            if (frame_done_a !== done_exp[c]) begin
                n_fail++;
                $display("FAIL %s frame_done cyc %0d: got %b want %b", name, c, frame_done_a, done_exp[c]);
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (cap_at[c][ch]) begin
                    n_tests++;
                    if (pw_a[ch*15 +: 15] !== 15'(cap_v[c][ch])) begin
                        n_fail++;
                        $display("FAIL %s pw[%0d] cyc %0d: got %0d want %0d", name, ch, c,
                                 pw_a[ch*15 +: 15], cap_v[c][ch]);
                    end
                end
            end
            if (done_exp[c]) begin
                n_tests++;
                if (thrst_a !== 17'(thr_exp[c])) begin
                    n_fail++;
                    $display("FAIL %s thrst cyc %0d: got %0d want %0d", name, c, thrst_a, thr_exp[c]);
                end
            end
        end
        esc_a = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({pw_a, pw_vld_a, frame_done_a, thrst_a, stale_a, ovf_a,
             pw_b, pw_vld_b, frame_done_b, thrst_b, stale_b, ovf_b,
             pw_c, pw_vld_c, frame_done_c, thrst_c, stale_c, ovf_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got a=%h/%h b=%h/%h c=%h/%h want all zero",
                     pw_a, thrst_a, pw_b, thrst_b, pw_c, thrst_c);
        end
        do_reset();
    endtask

    task automatic test_simultaneous();
        int st[4] = '{5, 5, 5, 5};
        int wd[4] = '{100, 100, 100, 100};
        int z[4]  = '{0, 0, 0, 0};
        run_a("simultaneous", st, wd, z, z, 1'b1);
    endtask

    task automatic test_staggered();
        int st[4] = '{0, 50, 120, 200};
        int wd[4] = '{100, 200, 300, 400};
        int z[4]  = '{0, 0, 0, 0};
        run_a("staggered", st, wd, z, z, 1'b1);
    endtask

    task automatic test_back_to_back();
        int st[4]  = '{0, 30, 30, 30};
        int wd[4]  = '{20, 60, 60, 60};
        int st2[4] = '{0, 0, 0, 0};
        int wd2[4] = '{0, 0, 0, 0};
        run_a("final_simultaneous", st, wd, st2, wd2, 1'b1);
        st  = '{0, 100, 100, 100};
        wd  = '{20, 10, 30, 50};
        st2 = '{40, 0, 0, 0};
        wd2 = '{33, 0, 0, 0};
        run_a("double_capture", st, wd, st2, wd2, 1'b1);
    endtask

    task automatic test_random();
        int st[4], wd[4], st2[4], wd2[4];
        for (int it = 0; it < 8; it++) begin
            for (int ch = 0; ch < 4; ch++) begin
                wd[ch] = int'($urandom_range(1, 400));
                st[ch] = int'($urandom_range(0, 150));
                if ($urandom_range(0, 1) == 1) begin
                    st2[ch] = st[ch] + wd[ch] + int'($urandom_range(2, 60));
                    wd2[ch] = int'($urandom_range(1, 200));
                end else begin
                    st2[ch] = 0;
                    wd2[ch] = 0;
                end
            end
            run_a($sformatf("random%0d", it), st, wd, st2, wd2, 1'b1);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int st[4] = '{2, 2, 2, 2};
        int wd[4] = '{50, 50, 50, 50};
        int z[4]  = '{0, 0, 0, 0};
        int vld_cnt = 0;
        run_a("preload", st, wd, z, z, 1'b1);
        esc_a = 4'hf;
        repeat (40) tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({pw_a, pw_vld_a, frame_done_a, thrst_a, stale_a, ovf_a} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_pulse outputs: got pw=%h thrst=%0d want 0", pw_a, thrst_a);
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 20) esc_a = 4'h0;
            tick();
            if (pw_vld_a != 4'h0) vld_cnt++;
        end
        n_tests++;
        if (vld_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_pulse no_capture: got %0d strobes want 0", vld_cnt);
        end
        wd = '{77, 77, 77, 77};
        run_a("post_reset", st, wd, z, z, 1'b0);
    endtask

    task automatic test_offset();
        bit got0 = 0, got1 = 0;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            esc_b = {2'b00, 1'(c < 80), 1'(c < 30)};
            tick();
            if (pw_vld_b[0]) begin
                got0 = 1;
                n_tests++;
                if (pw_b[14:0] !== 15'(exp_pw(30, 15, 50))) begin
                    n_fail++;
                    $display("FAIL offset ch0: got %0d want %0d", pw_b[14:0], exp_pw(30, 15, 50));
                end
            end
            if (pw_vld_b[1]) begin
                got1 = 1;
                n_tests++;
                if (pw_b[29:15] !== 15'(exp_pw(80, 15, 50))) begin
                    n_fail++;
                    $display("FAIL offset ch1: got %0d want %0d", pw_b[29:15], exp_pw(80, 15, 50));
                end
            end
        end
        n_tests++;
        if ({got1, got0} !== 2'b11) begin
            n_fail++;
            $display("FAIL offset captured: got %b want 11", {got1, got0});
        end
    endtask

    task automatic test_saturation();
        bit got = 0;
        do_reset();
        for (int c = 0; c < 320; c++) begin
            esc_c = {3'b000, 1'(c < 300)};
            tick();
            if (c == 100) begin
                n_tests++;
                if (ovf_c[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat early_ovf: got %b want 0", ovf_c[0]);
                end
            end
            if (pw_vld_c[0]) begin
                got = 1;
                n_tests++;
                if (pw_c[7:0] !== 8'(exp_pw(300, 8, 0)) || ovf_c[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat capture: got pw=%0d ovf=%b want pw=%0d ovf=1",
                             pw_c[7:0], ovf_c[0], exp_pw(300, 8, 0));
                end
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL sat captured: got 0 want 1");
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_tests++;
        if (ovf_c !== 4'h0) begin
            n_fail++;
            $display("FAIL sat clr_err: got %b want 0000", ovf_c);
        end
    endtask

    task automatic test_stale();
        do_reset();
        for (int c = 0; c < 1040; c++) begin
            esc_c = {1'b0, 1'((c < 10) || (c >= 1020 && c < 1030)), 2'b00};
            tick();
            if (c == 1001 || c == 1022) begin
                n_tests++;
                if (stale_c[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stale cyc %0d: got %b want 0", c, stale_c[2]);
                end
            end
            if (c == 1002 || c == 1021) begin
                n_tests++;
                if (stale_c[2] !== 1'b1 || stale_c[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stale cyc %0d: got ch2=%b ch0=%b want 1 1", c, stale_c[2], stale_c[0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; clr_err = 1'b0;
        esc_a = '0; esc_b = '0; esc_c = '0;
        #2;
        test_reset();
        test_simultaneous();
        test_staggered();
        test_back_to_back();
        test_random();
        test_reset_mid_pulse();
        test_offset();
        test_saturation();
        test_stale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
